serial_link_controller: RTL

Half-duplex sequencer for the 12-bit serial shift register. It shares that single register between an 8-bit transmit requester and the incoming serial line. It drives the register's preset, load, shift and serial-in controls, generates bit timing from the system clock, and frames, de-frames and checks bytes. It sits between the byte-level user logic and the serial pins.

---
 rtl/serial_link_controller.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_link_controller.sv
// serial_link_controller
// Half-duplex sequencer for an external 12-bit serial shift register.
// It generates bit timing and drives the preset, load and shift strobes.
// It frames outgoing bytes and de-frames and checks incoming frames.
// Frame layout, first bit on the wire at bit 0:
//   {stop, stop, parity, data[7:0], start}
module serial_link_controller #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        rx_line,
  output logic        tx_line,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_parity_err,
  output logic        rx_frame_err,
  output logic        busy,
  output logic        sr_preset_n,
  output logic        sr_load,
  output logic        sr_shift,
  output logic [11:0] sr_d_in,
  output logic        sr_rx,
  input  logic        sr_tx,
  input  logic [11:0] sr_d_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_LOAD  = 3'd1,
    ST_TX_BITS  = 3'd2,
    ST_RX_START = 3'd3,
    ST_RX_BITS  = 3'd4,
    ST_RX_DONE  = 3'd5
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] baud_r, baud_nxt_s;
  logic [3:0]    bit_r, bit_nxt_s;
  logic [1:0]    sync_r;
  logic [7:0]    tx_byte_r;
  logic [7:0]    rx_data_r;
  logic          rx_perr_r, rx_ferr_r;
  logic          rxs_s;
  logic          tx_ready_s, load_s, shift_s, done_s, capture_s;
  logic          rx_perr_s, rx_ferr_s;

  // Parity bit for a data byte: XOR of all data bits, inverted for odd parity.
  function automatic logic parity_of(input logic [7:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  assign rxs_s = sync_r[1];

  // Two-flop synchroniser on the asynchronous serial input, idling high.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_line};
    end
  end

  // State, baud counter and bit counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      baud_r  <= {CW{1'b0}};
      bit_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      baud_r  <= baud_nxt_s;
      bit_r   <= bit_nxt_s;
    end
  end

  // Capture the byte to send on the transmit handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_byte_r <= 8'h00;
    end else if (capture_s) begin
      tx_byte_r <= tx_data;
    end
  end

  // Hold the last received byte and its error flags until the next frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data_r <= 8'h00;
      rx_perr_r <= 1'b0;
      rx_ferr_r <= 1'b0;
    end else if (done_s) begin
      rx_data_r <= sr_d_out[8:1];
      rx_perr_r <= rx_perr_s;
      rx_ferr_r <= rx_ferr_s;
    end
  end

  // Next-state and strobe decode; receive wins over transmit in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_r;
    bit_nxt_s   = bit_r;
    tx_ready_s  = 1'b0;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    done_s      = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_ready_s = rxs_s;
        baud_nxt_s = {CW{1'b0}};
        bit_nxt_s  = 4'd0;
        if (!rxs_s) begin
          state_nxt_s = ST_RX_START;
        end else if (tx_valid) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_TX_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TX_LOAD: begin
        load_s      = 1'b1;
        baud_nxt_s  = {CW{1'b0}};
        bit_nxt_s   = 4'd0;
        state_nxt_s = ST_TX_BITS;
      end
      ST_TX_BITS: begin
        if (baud_r == BAUD_LAST) begin
          shift_s    = 1'b1;
          baud_nxt_s = {CW{1'b0}};
          if (bit_r == 4'd11) begin
            state_nxt_s = ST_IDLE;
          end else begin
            bit_nxt_s = bit_r + 4'd1;
          end
        end else begin
          baud_nxt_s = baud_r + CW'(1);
        end
      end
      ST_RX_START: begin
        if (baud_r == HALF_LAST) begin
          baud_nxt_s = {CW{1'b0}};
          if (rxs_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            shift_s     = 1'b1;
            bit_nxt_s   = 4'd0;
            state_nxt_s = ST_RX_BITS;
          end
        end else begin
          baud_nxt_s = baud_r + CW'(1);
        end
      end
      ST_RX_BITS: begin
        if (baud_r == BAUD_LAST) begin
          shift_s    = 1'b1;
          baud_nxt_s = {CW{1'b0}};
          if (bit_r == 4'd10) begin
            state_nxt_s = ST_RX_DONE;
          end else begin
            bit_nxt_s = bit_r + 4'd1;
          end
        end else begin
          baud_nxt_s = baud_r + CW'(1);
        end
      end
      ST_RX_DONE: begin
        done_s      = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Frame checks on the completed receive register contents.
  always_comb begin
    rx_perr_s = (sr_d_out[9] != parity_of(sr_d_out[8:1]));
    rx_ferr_s = sr_d_out[0] | (sr_d_out[11:10] != 2'b11);
  end

  // Output decode: reset gates every strobe and parks the serial pins high.
  always_comb begin
    tx_ready      = tx_ready_s & ~reset;
    sr_load       = load_s & ~reset;
    sr_shift      = shift_s & ~reset;
    rx_valid      = done_s & ~reset;
    sr_preset_n   = ~(reset | done_s);
    busy          = (state_r != ST_IDLE) & ~reset;
    sr_d_in       = {2'b11, parity_of(tx_byte_r), tx_byte_r, 1'b0};
    rx_data       = rx_valid ? sr_d_out[8:1] : rx_data_r;
    rx_parity_err = rx_valid ? rx_perr_s : rx_perr_r;
    rx_frame_err  = rx_valid ? rx_ferr_s : rx_ferr_r;
    if (reset) begin
      tx_line = 1'b1;
    end else if ((state_r == ST_TX_LOAD) || (state_r == ST_TX_BITS)) begin
      tx_line = sr_tx;
    end else begin
      tx_line = 1'b1;
    end
    if ((state_r == ST_RX_START) || (state_r == ST_RX_BITS) || (state_r == ST_RX_DONE)) begin
      sr_rx = rxs_s;
    end else begin
      sr_rx = 1'b1;
    end
  end

endmodule
